// File: rtl/alu_checker.sv
// Two-stage checker that shadows a combinational ALU: stage 1 registers each
// accepted sample, stage 2 recomputes y/t, scores it and captures the first failure.
module alu_checker #(
  parameter int WIDTH = 32,
  parameter int CW    = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             clear,
  input  logic             stop_on_fail,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       f,
  input  logic [WIDTH-1:0] y,
  input  logic [2:0]       t,
  output logic             ready,
  output logic [CW-1:0]    pass_cnt,
  output logic [CW-1:0]    fail_cnt,
  output logic             err,
  output logic             halted,
  output logic [WIDTH-1:0] ff_a,
  output logic [WIDTH-1:0] ff_b,
  output logic [WIDTH-1:0] ff_y_exp,
  output logic [WIDTH-1:0] ff_y_got,
  output logic [2:0]       ff_f,
  output logic [2:0]       ff_t_exp,
  output logic [2:0]       ff_t_got
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       f;
    logic [WIDTH-1:0] y;
    logic [2:0]       t;
  } smp_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       f;
    logic [WIDTH-1:0] y_exp;
    logic [WIDTH-1:0] y_got;
    logic [2:0]       t_exp;
    logic [2:0]       t_got;
  } ffrec_t;

  logic [1:0]    state_q, state_d;
  logic          s1_vld_q, s1_vld_d;
  smp_t          s1_q, s1_d;
  logic [CW-1:0] pass_cnt_q, pass_cnt_d;
  logic [CW-1:0] fail_cnt_q, fail_cnt_d;
  logic          err_q, err_d;
  logic          ff_vld_q, ff_vld_d;
  ffrec_t        ff_q, ff_d;

  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] y_exp;
  logic [2:0]       t_exp;
  logic             mismatch;
  logic             accept;

  assign ready  = (state_q == RUN);
  assign halted = (state_q == HALT);
  assign accept = in_valid && ready;

  // Stage 2: reference result from the registered operands
  assign sh = s1_q.b[SHW-1:0];

  always_comb begin
    y_exp = '0;
    case (s1_q.f)
      3'b000:  y_exp = s1_q.a - s1_q.b;
      3'b001:  y_exp = s1_q.a + s1_q.b;
      3'b010:  y_exp = s1_q.a & s1_q.b;
      3'b011:  y_exp = s1_q.a | s1_q.b;
      3'b100:  y_exp = s1_q.a ^ s1_q.b;
      3'b101:  y_exp = s1_q.a >> sh;
      3'b110:  y_exp = s1_q.a << sh;
      default: y_exp = $signed(s1_q.a) >>> sh;
    endcase
  end

  assign t_exp    = {s1_q.a < s1_q.b, $signed(s1_q.a) < $signed(s1_q.b), s1_q.a == s1_q.b};
  assign mismatch = s1_vld_q && ((s1_q.y != y_exp) || (s1_q.t != t_exp));

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = RUN;
        RUN:     if (mismatch && stop_on_fail) state_d = HALT;
        HALT:    state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    s1_vld_d   = accept && !clear;
    s1_d       = accept ? smp_t'{a: a, b: b, f: f, y: y, t: t} : s1_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    err_d      = err_q;
    ff_vld_d   = ff_vld_q;
    ff_d       = ff_q;
    if (clear) begin
      pass_cnt_d = '0;
      fail_cnt_d = '0;
      err_d      = 1'b0;
      ff_vld_d   = 1'b0;
      ff_d       = '0;
    end else if (s1_vld_q) begin
      if (mismatch) begin
        if (fail_cnt_q != {CW{1'b1}}) fail_cnt_d = fail_cnt_q + CW'(1);
        err_d = 1'b1;
        // Only the first failure since reset/clear is captured
        if (!ff_vld_q) begin
          ff_vld_d = 1'b1;
          ff_d     = ffrec_t'{a: s1_q.a, b: s1_q.b, f: s1_q.f, y_exp: y_exp,
                              y_got: s1_q.y, t_exp: t_exp, t_got: s1_q.t};
        end
      end else if (pass_cnt_q != {CW{1'b1}}) begin
        pass_cnt_d = pass_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      s1_vld_q   <= 1'b0;
      s1_q       <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      err_q      <= 1'b0;
      ff_vld_q   <= 1'b0;
      ff_q       <= '0;
    end else begin
      state_q    <= state_d;
      s1_vld_q   <= s1_vld_d;
      s1_q       <= s1_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      err_q      <= err_d;
      ff_vld_q   <= ff_vld_d;
      ff_q       <= ff_d;
    end
  end

  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;
  assign err      = err_q;
  assign ff_a     = ff_q.a;
  assign ff_b     = ff_q.b;
  assign ff_f     = ff_q.f;
  assign ff_y_exp = ff_q.y_exp;
  assign ff_y_got = ff_q.y_got;
  assign ff_t_exp = ff_q.t_exp;
  assign ff_t_got = ff_q.t_got;

endmodule

// File: tb/tb_alu_checker.sv
// Randomized + directed bench for alu_checker against a transaction-level model.
module tb_alu_checker;

  logic        clk = 1'b0;
  logic        rstn, start, clear, stop_on_fail, in_valid;
  logic [31:0] a, b, y;
  logic [2:0]  f, t;

  logic        ready, err, halted;
  logic [15:0] pass_cnt, fail_cnt;
  logic [31:0] ff_a, ff_b, ff_y_exp, ff_y_got;
  logic [2:0]  ff_f, ff_t_exp, ff_t_got;

  logic        d4_ready, d4_err, d4_halted;
  logic [3:0]  d4_pass, d4_fail;
  logic [31:0] d4_ff_a, d4_ff_b, d4_ff_y_exp, d4_ff_y_got;
  logic [2:0]  d4_ff_f, d4_ff_t_exp, d4_ff_t_got;

  always #5 clk = ~clk;

  alu_checker #(.WIDTH(32), .CW(16)) dut (
    .clk(clk), .rstn(rstn), .start(start), .clear(clear), .stop_on_fail(stop_on_fail),
    .in_valid(in_valid), .a(a), .b(b), .f(f), .y(y), .t(t),
    .ready(ready), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err(err), .halted(halted),
    .ff_a(ff_a), .ff_b(ff_b), .ff_y_exp(ff_y_exp), .ff_y_got(ff_y_got),
    .ff_f(ff_f), .ff_t_exp(ff_t_exp), .ff_t_got(ff_t_got));

  alu_checker #(.WIDTH(32), .CW(4)) dut4 (
    .clk(clk), .rstn(rstn), .start(start), .clear(clear), .stop_on_fail(stop_on_fail),
    .in_valid(in_valid), .a(a), .b(b), .f(f), .y(y), .t(t),
    .ready(d4_ready), .pass_cnt(d4_pass), .fail_cnt(d4_fail), .err(d4_err), .halted(d4_halted),
    .ff_a(d4_ff_a), .ff_b(d4_ff_b), .ff_y_exp(d4_ff_y_exp), .ff_y_got(d4_ff_y_got),
    .ff_f(d4_ff_f), .ff_t_exp(d4_ff_t_exp), .ff_t_got(d4_ff_t_got));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] a, b, y;
    logic [2:0]  f, t;
    int          due;
  } smp_t;

  smp_t        q[$];
  int          cyc = 0;
  int          m_state;          // 0 idle, 1 run, 2 halt
  int          m_pass, m_fail;
  bit          m_err, m_ffv;
  logic [31:0] m_ff_a, m_ff_b, m_ff_ye, m_ff_yg;
  logic [2:0]  m_ff_f, m_ff_te, m_ff_tg;

  function automatic logic [31:0] ref_y(input logic [31:0] aa, input logic [31:0] bb,
                                        input logic [2:0] fn);
    int sh;
    logic [31:0] r;
    sh = int'(bb % 32);
    r  = '0;
    case (fn)
      3'd0: r = aa - bb;
      3'd1: r = aa + bb;
      3'd2: r = aa & bb;
      3'd3: r = aa | bb;
      3'd4: r = aa ^ bb;
      3'd5: r = aa >> sh;
      3'd6: r = aa << sh;
      default:
        for (int k = 0; k < 32; k++) r[k] = (k + sh < 32) ? aa[k + sh] : aa[31];
    endcase
    return r;
  endfunction

  function automatic logic [2:0] ref_t(input logic [31:0] aa, input logic [31:0] bb);
    return {aa < bb, int'(aa) < int'(bb), aa == bb};
  endfunction

  task automatic model_reset();
    m_state = 0; m_pass = 0; m_fail = 0; m_err = 0; m_ffv = 0;
    m_ff_a = 0; m_ff_b = 0; m_ff_ye = 0; m_ff_yg = 0;
    m_ff_f = 0; m_ff_te = 0; m_ff_tg = 0;
    q.delete();
  endtask

  task automatic model_edge();
    smp_t s;
    int   nst;
    logic [31:0] ey;
    logic [2:0]  et;
    cyc++;
    if (clear) begin
      model_reset();
      return;
    end
    nst = m_state;
    while (q.size() > 0 && q[0].due == cyc) begin
      s  = q.pop_front();
      ey = ref_y(s.a, s.b, s.f);
      et = ref_t(s.a, s.b);
      if (s.y != ey || s.t != et) begin
        m_fail++;
        m_err = 1;
        if (!m_ffv) begin
          m_ffv = 1;
          m_ff_a = s.a; m_ff_b = s.b; m_ff_f = s.f;
          m_ff_ye = ey; m_ff_yg = s.y; m_ff_te = et; m_ff_tg = s.t;
        end
        if (m_state == 1 && stop_on_fail) nst = 2;
      end else begin
        m_pass++;
      end
    end
    if (m_state == 0 && start) nst = 1;
    if (m_state == 1 && in_valid) q.push_back('{a: a, b: b, y: y, f: f, t: t, due: cyc + 1});
    m_state = nst;
  endtask

  task automatic check_all();
    chk("ready",    ready,    m_state == 1);
    chk("halted",   halted,   m_state == 2);
    chk("err",      err,      m_err);
    chk("pass_cnt", pass_cnt, (m_pass > 65535) ? 65535 : m_pass);
    chk("fail_cnt", fail_cnt, (m_fail > 65535) ? 65535 : m_fail);
    chk("cw4_pass", d4_pass,  (m_pass > 15) ? 15 : m_pass);
    chk("cw4_fail", d4_fail,  (m_fail > 15) ? 15 : m_fail);
    chk("ff_a",     ff_a,     m_ff_a);
    chk("ff_b",     ff_b,     m_ff_b);
    chk("ff_f",     ff_f,     m_ff_f);
    chk("ff_y_exp", ff_y_exp, m_ff_ye);
    chk("ff_y_got", ff_y_got, m_ff_yg);
    chk("ff_t_exp", ff_t_exp, m_ff_te);
    chk("ff_t_got", ff_t_got, m_ff_tg);
  endtask

  // One clock: model and DUT advance on the same edge, then compare; pulses self-clear.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    start = 0; clear = 0; in_valid = 0;
  endtask

  task automatic smp(input logic [31:0] aa, input logic [31:0] bb, input logic [2:0] fn,
                     input logic [31:0] yy, input logic [2:0] tt);
    in_valid = 1; a = aa; b = bb; f = fn; y = yy; t = tt;
    step();
  endtask

  task automatic smp_ok(input logic [31:0] aa, input logic [31:0] bb, input logic [2:0] fn);
    smp(aa, bb, fn, ref_y(aa, bb, fn), ref_t(aa, bb));
  endtask

  initial begin
    logic [31:0] ra, rb, ry;
    logic [2:0]  rf, rt;
    int          r;

    rstn = 0; start = 0; clear = 0; stop_on_fail = 0; in_valid = 0;
    a = 0; b = 0; f = 0; y = 0; t = 0;
    model_reset();
    #12;
    check_all();
    rstn = 1;

    // basic add pass
    start = 1; step();
    smp(32'd5, 32'd3, 3'b001, 32'd8, 3'b000);
    step();
    chk("req033_pass", pass_cnt, 1);
    chk("req033_err", err, 0);

    // subtract wrap, then flag-only failure
    smp(32'hFFFF_FFFF, 32'd1, 3'b000, 32'hFFFF_FFFE, 3'b010);
    smp(32'hFFFF_FFFF, 32'd1, 3'b000, 32'hFFFF_FFFE, 3'b000);
    step();
    chk("req034_pass", pass_cnt, 2);
    chk("req034_fail", fail_cnt, 1);
    chk("req034_err", err, 1);
    chk("req034_te", ff_t_exp, 3'b010);
    chk("req034_tg", ff_t_got, 3'b000);

    // arithmetic vs logical shift with upper b bits ignored
    clear = 1; step();
    start = 1; step();
    smp(32'h8000_0000, 32'hFFFF_FFE4, 3'b111, 32'hF800_0000, 3'b110);
    smp(32'h8000_0000, 32'hFFFF_FFE4, 3'b101, 32'hF800_0000, 3'b110);
    step();
    chk("req035_pass", pass_cnt, 1);
    chk("req035_fail", fail_cnt, 1);
    chk("req035_ye", ff_y_exp, 32'h0800_0000);
    chk("req035_yg", ff_y_got, 32'hF800_0000);

    // stop_on_fail: mismatch then pass back to back
    clear = 1; step();
    stop_on_fail = 1;
    start = 1; step();
    smp(32'd1, 32'd2, 3'b001, 32'h63, 3'b110);
    smp_ok(32'd10, 32'd20, 3'b011);
    step();
    chk("req036_halt", halted, 1);
    chk("req036_ready", ready, 0);
    chk("req036_pass", pass_cnt, 1);
    chk("req036_fail", fail_cnt, 1);
    chk("req036_ffa", ff_a, 32'd1);
    chk("req036_ffyg", ff_y_got, 32'h63);
    start = 1; step();
    chk("req036_start_ign", halted, 1);
    clear = 1; step();
    chk("req036_clr_halt", halted, 0);
    chk("req036_clr_fail", fail_cnt, 0);
    chk("req036_clr_ffa", ff_a, 0);

    // saturation on the CW=4 instance
    stop_on_fail = 0;
    start = 1; step();
    for (int i = 0; i < 20; i++) smp_ok($urandom, $urandom, 3'($urandom_range(0, 7)));
    step();
    chk("req037_cw4", d4_pass, 4'd15);
    chk("req037_cw16", pass_cnt, 20);

    // clear coincident with an accepted mismatch, and with one in stage 2
    in_valid = 1; a = 7; b = 7; f = 3'b001; y = 0; t = 0; clear = 1;
    step();
    step();
    chk("req038a_fail", fail_cnt, 0);
    chk("req038a_err", err, 0);
    chk("req038a_idle", ready, 0);
    start = 1; step();
    smp(32'd7, 32'd7, 3'b001, 32'd0, 3'b000);
    clear = 1; step();
    chk("req038b_fail", fail_cnt, 0);
    chk("req038b_err", err, 0);

    // randomized traffic with an async reset in the middle
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) begin
        rstn = 0;
        #2;
        model_reset();
        chk("rst_async_pass", pass_cnt, 0);
        chk("rst_async_halt", halted, 0);
        check_all();
        @(negedge clk);
        rstn = 1;
      end
      r = int'($urandom_range(0, 99));
      if (r < 2) clear = 1;
      else if (r < 7) start = 1;
      if ($urandom_range(0, 199) == 0) stop_on_fail = ~stop_on_fail;
      in_valid = ($urandom_range(0, 9) < 7);
      ra = $urandom;
      rb = ($urandom_range(0, 9) == 0) ? ra : $urandom;
      rf = 3'($urandom_range(0, 7));
      ry = ref_y(ra, rb, rf);
      rt = ref_t(ra, rb);
      if ($urandom_range(0, 9) < 2) ry = ry ^ (32'd1 << $urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) rt = rt ^ 3'($urandom_range(1, 7));
      a = ra; b = rb; f = rf; y = ry; t = rt;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_checker.md
ALU_CHECKER -- requirements
Module: alu_checker

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, which sets the operand and result width; legal values are powers of two from 8 to 64.
REQ-002 The module SHALL have parameter CW, default 16, which sets the width of the pass and fail counters.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle pulse that arms the checker.
REQ-006 clear  input  1  one-cycle pulse that returns the checker to IDLE and zeroes its statistics.
REQ-007 stop_on_fail  input  1  when 1, the first mismatch halts checking.
REQ-008 in_valid  input  1  the current a/b/f/y/t sample is valid.
REQ-009 a, b  input  WIDTH  operands as driven to the ALU under test.
REQ-010 f  input  3  ALU function code.
REQ-011 y  input  WIDTH  result returned by the ALU under test.
REQ-012 t  input  3  flags returned by the ALU under test.
REQ-013 ready  output  1  high exactly when the state is RUN; samples are accepted only while ready is high.
REQ-014 pass_cnt, fail_cnt  output  CW  count of matching and mismatching samples.
REQ-015 err  output  1  sticky flag; set on any mismatch.
REQ-016 halted  output  1  high exactly when the state is HALT.
REQ-017 ff_a, ff_b, ff_y_exp, ff_y_got  output  WIDTH  capture of the first failing sample.
REQ-018 ff_f, ff_t_exp, ff_t_got  output  3  capture of the first failing sample.

Function
REQ-019 The state machine SHALL have three states with these transitions:
- IDLE goes to RUN on start.
- RUN goes to HALT on a mismatch when stop_on_fail=1.
- Any state goes to IDLE on clear.
- start is ignored in RUN and HALT.
- clear has priority over start and over a mismatch arriving in the same cycle.
REQ-020 A sample SHALL be accepted when in_valid && ready; the y and t inputs belong to the same cycle as a, b and f, because the ALU under test is combinational.
REQ-021 Stage 1 SHALL register each accepted sample. Stage 2 SHALL compute the expected y and t from the registered a, b and f, compare them with the registered y and t, and update the outputs on the next edge; total latency from acceptance to counter or err update is 2 cycles.
REQ-022 Expected y SHALL be computed per f, modulo 2^WIDTH:
- 000: a-b
- 001: a+b
- 010: a&b
- 011: a|b
- 100: a^b
- 101: a>>sh (logical)
- 110: a<<sh
- 111: a>>>sh (arithmetic)
- sh = b[log2(WIDTH)-1:0]; the upper bits of b are ignored for shifts.
REQ-023 Expected t SHALL be computed for every f, as:
- t[0]: a==b
- t[1]: $signed(a) < $signed(b)
- t[2]: a < b (unsigned)
REQ-024 A sample SHALL be a mismatch when y differs from expected y or t differs from expected t; otherwise it is a pass.
REQ-025 pass_cnt and fail_cnt SHALL saturate at 2^CW-1 and never wrap.
REQ-026 The ff_* registers SHALL load only on the first mismatch after reset or clear, and SHALL hold thereafter.
REQ-027 A sample already in stage 1 when HALT is entered SHALL still be compared and counted, but it SHALL NOT overwrite ff_*.
REQ-028 When clear is asserted, the stage-1 valid bit SHALL be dropped so that no in-flight sample is counted.
REQ-029 err SHALL be set in the same cycle that fail_cnt increments.

Reset
REQ-030 While rstn=0 the module SHALL hold:
- state IDLE
- ready=0, halted=0, err=0
- pass_cnt=0, fail_cnt=0
- all ff_* = 0
- stage-1 valid = 0
REQ-031 On rstn deassertion the module SHALL remain in IDLE until start.
REQ-032 The clear input SHALL produce the same register values as reset, synchronously.

Verification
REQ-033 Arm with start, stop_on_fail=0, then drive a=5, b=3, f=001, y=8, t=000 -> pass_cnt=1 two cycles later, err=0.
REQ-034 Drive a=32'hFFFF_FFFF, b=1, f=000, y=32'hFFFF_FFFE, t=3'b010 -> pass; then the same operands with t=3'b000 -> fail_cnt=1, err=1, ff_t_exp=010, ff_t_got=000.
REQ-035 Drive a=32'h8000_0000, b=32'hFFFF_FFE4, f=111, y=32'hF800_0000 -> pass (sh=4); then the same operands with f=101 and y=32'hF800_0000 -> fail, ff_y_exp=32'h0800_0000.
REQ-036 With stop_on_fail=1, drive a mismatch followed by a pass on back-to-back cycles:
- state becomes HALT and ready=0;
- the second sample is counted but ff_* holds the first mismatch;
- a later start is ignored;
- clear returns the block to IDLE with all outputs zero.
REQ-037 With CW=4, drive 20 passing samples -> pass_cnt=15.
REQ-038 Assert clear in the same cycle as an accepted mismatch -> IDLE with fail_cnt=0 and err=0.
REQ-039 Assert rstn=0 mid-stream -> all outputs are zero immediately, without waiting for a clock edge.
